// File: rtl/fifo_drain_packer.sv
// Drains an upstream FIFO one word at a time and packs the words into frames,
// flushing partial frames on idle timeout. Define PACKER_PARITY_EN to add frame_parity.
module fifo_drain_packer #(
  parameter int DATA_WIDTH      = 12,
  parameter int WORDS_PER_FRAME = 4,
  parameter int TIMEOUT         = 15,
  localparam int CW             = $clog2(WORDS_PER_FRAME + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fifo_empty,
  input  logic                                 fifo_valid,
  input  logic [DATA_WIDTH-1:0]                fifo_read_data,
  output logic                                 fifo_read_enable,
  output logic [DATA_WIDTH*WORDS_PER_FRAME-1:0] frame_data,
  output logic [DATA_WIDTH-1:0]                frame_checksum,
  output logic [CW-1:0]                        frame_count,
  output logic                                 frame_partial,
  output logic                                 frame_parity,
  output logic                                 frame_valid,
  input  logic                                 frame_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(WORDS_PER_FRAME);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS_PER_FRAME - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [7:0]    TO_M1    = 8'(TIMEOUT - 1);

  state_t                state_reg;
  logic [7:0]            idle_cnt_reg;
  logic [CW-1:0]         count_reg;
  logic [DATA_WIDTH-1:0] checksum_reg;
  logic                  rd_en_reg;
  logic                  valid_reg;
  logic                  partial_reg;

  logic store_word;
  logic transfer_done;
  logic frame_pending;

  assign store_word    = (state_reg == WAIT) && fifo_valid;
  assign transfer_done = (state_reg == EMIT) && frame_ready;
  assign frame_pending = (count_reg != '0) && (count_reg != FULL_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idle_cnt_reg <= '0;
      count_reg    <= '0;
      checksum_reg <= '0;
      rd_en_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      partial_reg  <= 1'b0;
    end else begin
      rd_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Timeout takes priority over a new read so a partial frame cannot be starved.
          if (frame_pending && idle_cnt_reg == TO_M1) begin
            idle_cnt_reg <= idle_cnt_reg + 8'd1;
            state_reg    <= EMIT;
            valid_reg    <= 1'b1;
            partial_reg  <= 1'b1;
          end else begin
            if (frame_pending) begin
              idle_cnt_reg <= idle_cnt_reg + 8'd1;
            end
            if (!fifo_empty) begin
              state_reg <= REQ;
              rd_en_reg <= 1'b1;
            end
          end
        end
        REQ: state_reg <= WAIT;
        WAIT: begin
          if (fifo_valid) begin
            count_reg    <= count_reg + ONE_CNT;
            checksum_reg <= checksum_reg + fifo_read_data;
            idle_cnt_reg <= '0;
            if (count_reg == LAST_CNT) begin
              state_reg <= EMIT;
              valid_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        EMIT: begin
          if (frame_ready) begin
            state_reg    <= IDLE;
            idle_cnt_reg <= '0;
            count_reg    <= '0;
            checksum_reg <= '0;
            valid_reg    <= 1'b0;
            partial_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Each slot is written only when the fill pointer selects it, so unfilled slots stay zero.
  for (genvar gi = 0; gi < WORDS_PER_FRAME; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_reg <= '0;
      end else if (transfer_done) begin
        slot_reg <= '0;
      end else if (store_word && count_reg == CW'(gi)) begin
        slot_reg <= fifo_read_data;
      end
    end
    assign frame_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
  end

`ifdef PACKER_PARITY_EN
  // Parity accumulates per stored word; empty slots contribute nothing.
  logic parity_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (transfer_done) begin
      parity_reg <= 1'b0;
    end else if (store_word) begin
      parity_reg <= parity_reg ^ (^fifo_read_data);
    end
  end
  assign frame_parity = parity_reg;
`else
  assign frame_parity = 1'b0;
`endif

  assign fifo_read_enable = rd_en_reg;
  assign frame_checksum   = checksum_reg;
  assign frame_count      = count_reg;
  assign frame_partial    = partial_reg;
  assign frame_valid      = valid_reg;

endmodule
